idli_retire_log_m: RTL and testbench

// - Parametrised retirement monitor/logger for the idli core; generalises the TB-only

---
 rtl/idli_pkg.sv | 32 +++
 rtl/idli_rl_fifo_m.sv | 56 +++++
 rtl/idli_retire_log_m.sv | 154 +++++++++++++++
 tb/tb_idli_retire_log_m.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared idli types plus the retire-log record.
// IDLI_RETIRE_LOG_TS_EN adds a 32-bit timestamp field to rl_rec_t.
package idli_pkg;

    typedef logic [1:0]  ctr_t;
    typedef logic [15:0] data_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_REG  = 2'd1,
        DST_P    = 2'd2,
        DST_MEM  = 2'd3
    } dst_t;

    localparam int RL_DROP_W = 8;
    localparam int RL_SEQ_W  = 8;
    localparam int RL_REG_W  = 4;
    localparam int RL_TS_W   = 32;

    typedef struct packed {
`ifdef IDLI_RETIRE_LOG_TS_EN
        logic [RL_TS_W-1:0]  ts;
`endif
        logic [RL_SEQ_W-1:0] seq;
        dst_t                dst;
        logic [RL_REG_W-1:0] dst_reg;
        logic                skip;
        data_t               data;
        logic                pred;
    } rl_rec_t;

endpackage

// File: rtl/idli_rl_fifo_m.sv
// Synchronous first-word-fall-through FIFO for retire records.
// Pointers carry one extra wrap bit so full/empty need no counter.
module idli_rl_fifo_m #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic i_gck,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_pop,
    input  T     i_data,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    T            mem_q [DEPTH];
    T            mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Status, pointer advance and storage write.
    always_comb begin
        o_empty = (wr_q == rd_q);
        o_full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = i_pop && !o_empty;
        do_push = i_push && (!o_full || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = i_data;
        o_data  = mem_q[rd_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge i_gck) begin
        if (i_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge i_gck) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/idli_retire_log_m.sv
// Retirement monitor: capture, scoreboard, sequence and overflow tracking.
// IDLI_RETIRE_LOG_TS_EN adds a free-running cycle timestamp to each record.
module idli_retire_log_m
    import idli_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int SEQ_W    = 8
) (
    input  logic                        i_rl_gck,
    input  logic                        i_rl_rst,
    input  ctr_t                        i_rl_ctr,
    input  logic                        i_rl_run,
    input  logic                        i_rl_skip,
    input  dst_t                        i_rl_dst,
    input  logic [$clog2(NUM_REGS)-1:0] i_rl_dst_reg,
    input  logic [DATA_W-1:0]           i_rl_wb_data,
    input  logic                        i_rl_pred,
    input  logic [NUM_REGS:0]           i_rl_sb_clr,
    output logic [NUM_REGS:0]           o_rl_sb,
    output logic                        o_rl_vld,
    input  logic                        i_rl_rdy,
    output rl_rec_t                     o_rl_rec,
    output logic                        o_rl_ovf,
    output logic [RL_DROP_W-1:0]        o_rl_drop_cnt
);

    localparam int REG_W = $clog2(NUM_REGS);

    logic                 done_q, done_d;
    logic                 pend_vld_q, pend_vld_d;
    dst_t                 pend_dst_q, pend_dst_d;
    logic [REG_W-1:0]     pend_reg_q, pend_reg_d;
    logic                 pend_skip_q, pend_skip_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [NUM_REGS:0]    sb_q, sb_d;
    logic                 ovf_q, ovf_d;
    logic [RL_DROP_W-1:0] drop_q, drop_d;
`ifdef IDLI_RETIRE_LOG_TS_EN
    logic [RL_TS_W-1:0]   ts_q, ts_d;
`endif

    logic    done;
    logic    pop;
    logic    drop;
    logic    full;
    logic    empty;
    rl_rec_t rec_in;
    rl_rec_t head;

    // Latch instruction fields at ctr==0 and flag completion after ctr==3.
    always_comb begin
        done_d      = (i_rl_ctr == 2'd3) && i_rl_run;
        pend_vld_d  = pend_vld_q;
        pend_dst_d  = pend_dst_q;
        pend_reg_d  = pend_reg_q;
        pend_skip_d = pend_skip_q;
        if ((i_rl_ctr == 2'd0) && i_rl_run) begin
            pend_vld_d  = 1'b1;
            pend_dst_d  = i_rl_dst;
            pend_reg_d  = i_rl_dst_reg;
            pend_skip_d = i_rl_skip;
        end
    end

    // Build the record, advance seq and track drops.
    always_comb begin
        done   = done_q && pend_vld_q;
        pop    = !empty && i_rl_rdy;
        drop   = done && full && !pop;
        rec_in = '0;
`ifdef IDLI_RETIRE_LOG_TS_EN
        rec_in.ts = ts_q;
        ts_d      = ts_q + 1'b1;
`endif
        rec_in.seq     = seq_q;
        rec_in.dst     = pend_dst_q;
        rec_in.dst_reg = pend_reg_q;
        rec_in.skip    = pend_skip_q;
        rec_in.data    = (pend_dst_q == DST_REG) ? i_rl_wb_data : '0;
        rec_in.pred    = i_rl_pred;
        seq_d  = done ? seq_q + 1'b1 : seq_q;
        ovf_d  = ovf_q | drop;
        drop_d = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    end

    // Scoreboard: clears always win over a same-cycle set.
    always_comb begin
        sb_d = sb_q & ~i_rl_sb_clr;
        if (done) begin
            if ((pend_dst_q == DST_REG) && (pend_reg_q != '0))
                sb_d[pend_reg_q] = !pend_skip_q && !i_rl_sb_clr[pend_reg_q];
            if (pend_dst_q == DST_P)
                sb_d[NUM_REGS] = !pend_skip_q && !i_rl_sb_clr[NUM_REGS];
        end
        sb_d[0] = 1'b0;
    end

    // State registers.
    always_ff @(posedge i_rl_gck) begin
        if (i_rl_rst) begin
            done_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_dst_q  <= DST_NONE;
            pend_reg_q  <= '0;
            pend_skip_q <= 1'b0;
            seq_q       <= '0;
            sb_q        <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
`ifdef IDLI_RETIRE_LOG_TS_EN
            ts_q        <= '0;
`endif
        end else begin
            done_q      <= done_d;
            pend_vld_q  <= pend_vld_d;
            pend_dst_q  <= pend_dst_d;
            pend_reg_q  <= pend_reg_d;
            pend_skip_q <= pend_skip_d;
            seq_q       <= seq_d;
            sb_q        <= sb_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
`ifdef IDLI_RETIRE_LOG_TS_EN
            ts_q        <= ts_d;
`endif
        end
    end

    idli_rl_fifo_m #(
        .DEPTH (DEPTH),
        .T     (rl_rec_t)
    ) u_fifo (
        .i_gck   (i_rl_gck),
        .i_rst   (i_rl_rst),
        .i_push  (done),
        .i_pop   (pop),
        .i_data  (rec_in),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty)
    );

    // Outputs; the head is masked while empty so reset shows a zero record.
    always_comb begin
        o_rl_sb       = sb_q;
        o_rl_vld      = !empty;
        o_rl_rec      = empty ? '0 : head;
        o_rl_ovf      = ovf_q;
        o_rl_drop_cnt = drop_q;
    end

endmodule

// File: tb/tb_idli_retire_log_m.sv
// Directed bench for idli_retire_log_m with a queue scoreboard.
module tb_idli_retire_log_m;
    import idli_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    ctr_t        ctr = '0;
    logic        run = 1'b0;
    logic        skip = 1'b0;
    dst_t        dst = DST_NONE;
    logic [3:0]  dreg = '0;
    logic [15:0] wb = '0;
    logic        pred = 1'b0;
    logic [16:0] clr = '0;
    logic [16:0] sb;
    logic        vld;
    logic        rdy = 1'b0;
    rl_rec_t     rec;
    logic        ovf;
    logic [7:0]  dcnt;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_seq = '0;
    rl_rec_t     exp_q[$];
    rl_rec_t     mon_e;

    always #5 clk = ~clk;

    idli_retire_log_m dut (
        .i_rl_gck      (clk),
        .i_rl_rst      (rst),
        .i_rl_ctr      (ctr),
        .i_rl_run      (run),
        .i_rl_skip     (skip),
        .i_rl_dst      (dst),
        .i_rl_dst_reg  (dreg),
        .i_rl_wb_data  (wb),
        .i_rl_pred     (pred),
        .i_rl_sb_clr   (clr),
        .o_rl_sb       (sb),
        .o_rl_vld      (vld),
        .i_rl_rdy      (rdy),
        .o_rl_rec      (rec),
        .o_rl_ovf      (ovf),
        .o_rl_drop_cnt (dcnt)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted head record must match the queue front.
    always @(negedge clk) begin
        if (!rst && vld && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rec_unexpected: got seq %0d expected none",
                         rec.seq);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec",
                    {32'h0, rec.seq, rec.dst, rec.dst_reg,
                     rec.skip, rec.data, rec.pred},
                    {32'h0, mon_e.seq, mon_e.dst, mon_e.dst_reg,
                     mon_e.skip, mon_e.data, mon_e.pred});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: 4 run cycles, then a done cycle and 3 idle cycles.
    task automatic instr(input dst_t d, input logic [3:0] r,
                         input logic s, input logic [15:0] w,
                         input logic p, input logic [16:0] c,
                         input logic exp_push, input logic rdy_done);
        rl_rec_t e;
        logic    saved;
        ctr = 2'd0; run = 1'b1; dst = d; dreg = r; skip = s;
        tick();
        ctr = 2'd1; dst = DST_NONE; dreg = '0; skip = 1'b0;
        tick();
        ctr = 2'd2;
        tick();
        ctr = 2'd3;
        tick();
        ctr = 2'd0; run = 1'b0; wb = w; pred = p; clr = c;
        saved = rdy;
        rdy = rdy | rdy_done;
        e = '0;
        e.seq = exp_seq;
        e.dst = d;
        e.dst_reg = r;
        e.skip = s;
        e.data = (d == DST_REG) ? w : 16'h0;
        e.pred = p;
        if (exp_push) exp_q.push_back(e);
        exp_seq = exp_seq + 8'd1;
        tick();
        rdy = saved; clr = '0; wb = '0; pred = 1'b0;
        if (exp_push) chk("vld_after_done", {63'h0, vld}, 64'h1);
        ctr = 2'd1;
        tick();
        ctr = 2'd2;
        tick();
        ctr = 2'd3;
        tick();
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int k = 0; k < 20 && vld; k++) tick();
        rdy = 1'b0;
        chk("drained_vld", {63'h0, vld}, 64'h0);
        chk("drained_queue", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sb", 64'(sb), 64'h0);
        chk("rst_vld", {63'h0, vld}, 64'h0);
        chk("rst_rec", 64'(rec), 64'h0);
        chk("rst_ovf", {63'h0, ovf}, 64'h0);
        chk("rst_drop", 64'(dcnt), 64'h0);

        rdy = 1'b1;
        instr(DST_REG, 4'd5, 1'b0, 16'hBEEF, 1'b0, '0, 1'b1, 1'b0);
        chk("sb_r5_set", 64'(sb), 64'h00020);
        instr(DST_P, 4'd0, 1'b1, 16'h1234, 1'b1, '0, 1'b1, 1'b0);
        chk("sb_p_skip", 64'(sb), 64'h00020);
        instr(DST_P, 4'd0, 1'b0, 16'h4321, 1'b1, '0, 1'b1, 1'b0);
        chk("sb_p_set", 64'(sb), 64'h10020);
        instr(DST_REG, 4'd5, 1'b0, 16'h5555, 1'b0, 17'h00020, 1'b1, 1'b0);
        chk("sb_clr_wins", 64'(sb), 64'h10000);
        clr = 17'h10000;
        tick();
        clr = '0;
        chk("sb_clr_pred", 64'(sb), 64'h0);
        instr(DST_REG, 4'd9, 1'b0, 16'h0909, 1'b1, '0, 1'b1, 1'b0);
        chk("sb_r9_set", 64'(sb), 64'h00200);

        ctr = 2'd0; run = 1'b1; dst = DST_REG; dreg = 4'd3;
        tick();
        ctr = 2'd1; dst = DST_NONE; dreg = '0;
        tick();
        ctr = 2'd2; rst = 1'b1;
        tick();
        rst = 1'b0; ctr = 2'd3;
        tick();
        ctr = 2'd0; run = 1'b0; wb = 16'h3333;
        tick();
        wb = '0;
        chk("mid_rst_vld", {63'h0, vld}, 64'h0);
        chk("mid_rst_sb", 64'(sb), 64'h0);
        ctr = 2'd1;
        tick();
        ctr = 2'd2;
        tick();
        ctr = 2'd3;
        tick();
        chk("mid_rst_vld2", {63'h0, vld}, 64'h0);
        exp_seq = '0;

        rdy = 1'b0;
        for (int i = 0; i < 10; i++)
            instr(DST_REG, 4'(i + 1), 1'b0, 16'h1000 + 16'(i),
                  i[0], '0, i < 8, 1'b0);
        chk("ovf_flag", {63'h0, ovf}, 64'h1);
        chk("ovf_drop", 64'(dcnt), 64'h2);
        chk("ovf_vld", {63'h0, vld}, 64'h1);
        drain();

        for (int i = 0; i < 8; i++)
            instr(DST_REG, 4'(15 - i), 1'b0, 16'hA000 + 16'(i),
                  1'b0, '0, 1'b1, 1'b0);
        instr(DST_REG, 4'd0, 1'b0, 16'hDEAD, 1'b1, '0, 1'b1, 1'b1);
        chk("full_pp_drop", 64'(dcnt), 64'h2);
        chk("full_pp_vld", {63'h0, vld}, 64'h1);
        chk("r0_not_sb", {63'h0, sb[0]}, 64'h0);
        drain();
        chk("final_ovf", {63'h0, ovf}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
